// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl: keyed ring-oscillator edge counter with single-key or four-key sweep.
module ro_measure_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sweep,
  input  logic [1:0]       k_sel,
  input  logic [WIN_W-1:0] window,
  input  logic             ro_out,
  output logic             ro_enable,
  output logic [1:0]       ro_k,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             res_valid,
  output logic [1:0]       res_k,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = WIN_W > SW ? WIN_W : SW;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETL, S_MEAS, S_DRAIN} state_t;
  state_t state, nxt;
  logic go, acc, sw_q, ab, s1, s2, s3, sat, sat_nx, edge_ro;
  logic set_end, meas_end, last_key, fin, end_run;
  logic [1:0] ks_q;
  logic [WIN_W-1:0] win_q, win_last;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] cnt, cnt_nx;
  // a start is registered for one cycle in IDLE before LOAD so config is stable
  assign acc = state == S_IDLE && start && !go;
  assign edge_ro = s2 && !s3;
  assign win_last = win_q == '0 ? '0 : win_q - 1'b1;
  assign set_end = tmr == TW'(SETTLE - 1);
  assign meas_end = tmr == TW'(win_last);
  assign last_key = !sw_q || ro_k == 2'd3;
  assign cnt_nx = state == S_MEAS ? cnt + CNT_W'(edge_ro && !(&cnt)) : state == S_DRAIN ? cnt : '0;
  assign sat_nx = state == S_MEAS ? sat || (edge_ro && (&cnt)) : state == S_DRAIN && sat;
  assign fin = state == S_MEAS && meas_end && !abort;
  assign end_run = state == S_DRAIN && nxt == S_IDLE;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = go ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = abort ? S_DRAIN : S_SETL;
      S_SETL:  nxt = abort ? S_DRAIN : set_end ? S_MEAS : S_SETL;
      S_MEAS:  nxt = abort || meas_end ? S_DRAIN : S_MEAS;
      S_DRAIN: nxt = !set_end ? S_DRAIN : ab || abort || last_key ? S_IDLE : S_LOAD;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      {s1, s2, s3} <= '0;
      go <= 1'b0;
      {sw_q, ks_q, win_q} <= '0;
      tmr <= '0;
      cnt <= '0;
      sat <= 1'b0;
      ab <= 1'b0;
      ro_k <= '0;
      ro_enable <= 1'b0;
      busy <= 1'b0;
      res_valid <= 1'b0;
      res_k <= '0;
      res_count <= '0;
      res_sat <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= nxt;
      {s1, s2, s3} <= {ro_out, s1, s2};
      go <= acc;
      if (acc) {sw_q, ks_q, win_q} <= {sweep, k_sel, window};
      tmr <= nxt != state ? '0 : tmr + 1'b1;
      cnt <= cnt_nx;
      sat <= sat_nx;
      ab <= go ? 1'b0 : ab || (abort && state != S_IDLE);
      if (nxt == S_LOAD) ro_k <= state == S_IDLE ? (sw_q ? 2'd0 : ks_q) : ro_k + 2'd1;
      ro_enable <= nxt == S_SETL || nxt == S_MEAS;
      busy <= nxt != S_IDLE;
      res_valid <= fin;
      if (fin) begin
        res_k <= ro_k;
        res_count <= cnt_nx;
        res_sat <= sat_nx;
      end
      done <= end_run;
      aborted <= end_run && (ab || abort);
    end
  end
endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb_ro_measure_ctrl: randomized runs checked cycle by cycle against a timeline model.
module tb_ro_measure_ctrl;
  localparam int CNT_W = 5, WIN_W = 8, SETTLE = 16;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int CW = 3 + WIN_W;
  logic clk = 1'b0, clk_en = 1'b1, rst = 1'b1, start = 1'b0, abort = 1'b0, sweep = 1'b0, ro_out = 1'b0;
  logic [1:0] k_sel = '0;
  logic [WIN_W-1:0] window = '0;
  logic ro_enable, busy, done, aborted, res_valid, res_sat;
  logic [1:0] ro_k, res_k;
  logic [CNT_W-1:0] res_count;
  int errs = 0, checks = 0, ecnt = 0, ph = 0, ro_h = 5;
  bit ro_rnd = 1'b0;
  logic hist [0:65535];
  ro_measure_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sweep(sweep), .k_sel(k_sel),
    .window(window), .ro_out(ro_out), .ro_enable(ro_enable), .ro_k(ro_k), .busy(busy),
    .done(done), .aborted(aborted), .res_valid(res_valid), .res_k(res_k),
    .res_count(res_count), .res_sat(res_sat)
  );
  initial forever #5 clk = clk_en ? ~clk : clk;
  always @(posedge clk) begin
    hist[ecnt] <= ro_out;
    ecnt <= ecnt + 1;
  end
  always @(negedge clk) begin
    ph++;
    ro_out = ro_rnd ? 1'($urandom) : 1'((ph / ro_h) % 2);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int rises(input int lo, input int hi);
    int r = 0;
    for (int n = lo; n <= hi; n++) r += int'(hist[n] && !hist[n-1]);
    return r;
  endfunction
  task automatic chk_reset_outputs();
    chk("rst_ro_enable", 32'(ro_enable), 0);
    chk("rst_ro_k", 32'(ro_k), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_aborted", 32'(aborted), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_k", 32'(res_k), 0);
    chk("rst_res_count", 32'(res_count), 0);
    chk("rst_res_sat", 32'(res_sat), 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ro_enable", 32'(ro_enable), 0);
      chk("idle_done", 32'(done), 0);
    end
  endtask
  // Event times are edges relative to the edge that samples start; key i loads at 1+i*p.
  task automatic run(input bit sw, input logic [1:0] ks, input int win, input int ab_at, input int rst_at);
    int w, p, nk, dn, t0, rs, en, rv, key, lo, c, l, ia;
    bit hasab;
    w = win == 0 ? 1 : win;
    p = 2 * SETTLE + w + 1;
    nk = sw ? 4 : 1;
    hasab = ab_at >= 2;
    t0 = 0;
    if (!hasab) dn = 1 + nk * p;
    else begin
      ia = (ab_at - 2) / p;
      l = 1 + ia * p;
      dn = ab_at - l <= SETTLE + w ? ab_at + SETTLE : l + p;
    end
    rs = 2 + $urandom_range(dn - 3, 0);
    for (int rel = 0; rel <= dn + 2; rel++) begin
      @(negedge clk);
      if (rel == rst_at) begin
        clk_en = 1'b0;
        #20 rst = 1'b1;
        #1 chk_reset_outputs();
        #10 rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        clk_en = 1'b1;
        return;
      end
      start = rel == 0 || rel == rs;
      abort = rel == ab_at;
      if (rel == 0) {sweep, k_sel, window} = {sw, ks, WIN_W'(win)};
      else if (rel == 1 || rel == rs) {sweep, k_sel, window} = CW'($urandom);
      @(posedge clk);
      #1;
      if (rel == 0) t0 = ecnt - 1;
      en = 0;
      rv = 0;
      key = 0;
      lo = 0;
      for (int i = 0; i < nk; i++) begin
        l = 1 + i * p;
        if (!hasab || ab_at > l) begin
          if (rel >= l + 1 && rel <= l + SETTLE + w && (!hasab || rel < ab_at)) begin
            en = 1;
            key = sw ? i : int'(ks);
          end
          if (rel == l + SETTLE + w + 1 && (!hasab || ab_at > rel)) begin
            rv = 1;
            key = sw ? i : int'(ks);
            lo = l + SETTLE;
          end
        end
      end
      chk("ro_enable", 32'(ro_enable), en);
      chk("busy", 32'(busy), 32'(rel >= 1 && rel < dn));
      chk("res_valid", 32'(res_valid), rv);
      chk("done", 32'(done), 32'(rel == dn));
      if (rel == dn) chk("aborted", 32'(aborted), 32'(hasab));
      if (en != 0) chk("ro_k", 32'(ro_k), key);
      if (rv != 0) begin
        c = rises(t0 + lo, t0 + lo + w - 1);
        chk("res_k", 32'(res_k), key);
        chk("res_count", 32'(res_count), c > MAXC ? MAXC : c);
        chk("res_sat", 32'(res_sat), 32'(c > MAXC));
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask
  initial begin
    int w, p, ab;
    bit sw;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    @(negedge clk) rst = 1'b0;
    idle(4);
    ro_h = 5;
    run(1'b0, 2'd2, 100, -1, -1);
    idle(2);
    run(1'b1, 2'd2, 100, -1, -1);
    idle(2);
    ro_h = 1;
    run(1'b0, 2'd1, 100, -1, -1);
    ro_h = 3;
    run(1'b1, 2'd0, 60, 94 + SETTLE + 10, -1);
    run(1'b0, 2'd3, 0, -1, -1);
    run(1'b0, 2'd1, 20, 0, -1);
    run(1'b1, 2'd0, 20, 100, -1);
    run(1'b1, 2'd0, 20, 2, -1);
    ro_h = 2;
    run(1'b1, 2'd0, 50, -1, 1 + SETTLE + 10);
    idle(4);
    run(1'b0, 2'd2, 30, -1, -1);
    for (int t = 0; t < 25; t++) begin
      sw = 1'($urandom);
      w = $urandom_range(60, 0);
      p = 2 * SETTLE + (w == 0 ? 1 : w) + 1;
      ab = $urandom_range(3, 0) == 0 ? $urandom_range((sw ? 4 : 1) * p, 0) : -1;
      ro_rnd = $urandom_range(2, 0) == 0;
      ro_h = $urandom_range(6, 1);
      run(sw, 2'($urandom), w, ab, -1);
      idle($urandom_range(3, 1));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ro_measure_ctrl.md
# ro_measure_ctrl

Measurement controller for the keyed ring oscillator. It enables the oscillator and drives its 2-bit delay-select key, either for one key or as a sweep over all four. For each key it counts oscillator rising edges over a programmable window of system-clock cycles and reports one result per key. It sits between the ring oscillator instance and the host/test logic that calibrates or characterises it.

## Interface
Parameters:
- CNT_W, 16: width of the edge counter and `res_count`.
- WIN_W, 16: width of `window`.
- SETTLE, 16: number of clk cycles in each SETTLE and DRAIN phase; must be ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a measurement; accepted only in IDLE.
- abort  in  1  abandon the current run; ignored in IDLE.
- sweep  in  1  1: measure K=0,1,2,3 in that order; 0: measure `k_sel` only.
- k_sel  in  2  key used when `sweep`=0.
- window  in  WIN_W  measurement length in clk cycles; a value of 0 is treated as 1.
- ro_out  in  1  ring oscillator output; asynchronous to clk.
- ro_enable  out  1  oscillator enable.
- ro_k  out  2  oscillator key.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run ends.
- aborted  out  1  valid with `done`; 1 if the run ended by `abort`.
- res_valid  out  1  one-cycle pulse per completed key.
- res_k  out  2  key of the current result.
- res_count  out  CNT_W  edge count of the current result.
- res_sat  out  1  the count saturated.

## Operation
- Synchronizer: `ro_out` passes through 2 flops (s1, s2), then a history flop s3. An edge is s2 & ~s3. The synchronizer runs in every state.
- FSM states: IDLE, LOAD, SETTLE, MEASURE, DRAIN.
- IDLE, `start`=1: latch `sweep`, `k_sel` and `window` (later changes to these inputs are ignored). Go to LOAD.
- LOAD (1 cycle): load `ro_k` with the first key (0 for a sweep, `k_sel` otherwise). `ro_enable` stays 0. Go to SETTLE.
- SETTLE (SETTLE cycles): `ro_enable`=1 and the counter is held at 0. Go to MEASURE.
- MEASURE (window cycles): the counter increments on each edge and saturates at all ones; a sticky saturation flag is set. Go to DRAIN.
- DRAIN entry: `ro_enable`=0 and `res_valid` pulses with `res_k`=`ro_k`, `res_count` and `res_sat`. `res_*` hold until the next `res_valid`.
- DRAIN (SETTLE cycles), then:
  - keys remain: go to LOAD with the next key;
  - no keys remain: go to IDLE and pulse `done` with `aborted`=0.
- `ro_k` changes only in LOAD, so it is never changed while `ro_enable`=1.
- `abort` in LOAD, SETTLE or MEASURE: go to DRAIN on the next edge, with no `res_valid`. After DRAIN, go to IDLE and pulse `done` with `aborted`=1.
- `abort` in DRAIN: no remaining keys are run.
- `abort` and `start` together in IDLE: `start` wins.
- `start` while `busy`=1 is ignored.
- Accuracy: counts are exact only when f_ro < f_clk/2. Aliasing above that is not detected.

## Timing
- Reset values: `ro_enable`=0, `ro_k`=0, `busy`=0, `done`=0, `aborted`=0, `res_valid`=0, `res_k`=0, `res_count`=0, `res_sat`=0. Synchronizer flops and FSM are cleared; state is IDLE.
- Reset is asynchronous: `ro_enable` drops immediately, with no clock edge needed, including mid-MEASURE.
- For `start` sampled at edge 0 (W = effective window):
  - LOAD in cycle 1;
  - `ro_enable` rises at edge 2;
  - MEASURE spans cycles SETTLE+2 .. SETTLE+W+1;
  - `res_valid` and the `ro_enable` fall occur at edge SETTLE+W+2;
  - `done` occurs at edge 2·SETTLE+W+2, the same edge at which `busy` falls.
- Sweep: each key adds 2·SETTLE+W+1 cycles. Between measurements `ro_enable` is low for SETTLE+1 cycles.
- Edge latency: 3 cycles. Edges still in the synchronizer when MEASURE ends are not counted.

## Test plan
- Reset: assert `rst` mid-MEASURE with clk stopped → `ro_enable`=0 at once; all outputs hold reset values; state is IDLE after release.
- Single measurement: SETTLE=16, `sweep`=0, `k_sel`=2, `window`=100, `ro_out` period 10 clk → `ro_k`=2; `res_valid` at edge 118 with `res_k`=2, `res_count`=10±1, `res_sat`=0; `done` at edge 134.
- Sweep: same stimulus with `sweep`=1 → four `res_valid` pulses with `res_k`=0,1,2,3; `ro_k` is never changed while `ro_enable`=1; `ro_enable` is low ≥17 cycles between measurements; a single `done` with `aborted`=0.
- Saturation: CNT_W=4, `ro_out` period 4 clk, `window`=100 → `res_count`=15, `res_sat`=1.
- Abort: `abort` in MEASURE of the second sweep key → `ro_enable`=0 on the next edge; no second `res_valid`; `done` and `aborted`=1 SETTLE cycles later.
- Corner cases: `window`=0 → MEASURE lasts 1 cycle; `start` pulsed while `busy`=1 → ignored, exactly one run completes.
